hazard_ctrl: RTL

Pipeline hazard and stall controller for the 5-stage MIPS core. Detects load-use hazards between the ID and EX stages, flushes IF/ID on taken branches, and freezes the whole pipeline while data memory is busy, with a timeout watchdog. Its outputs drive the write enables of the PC and IF/ID registers, the bubble mux in front of the ID/EX control fields, and the enables of the ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_ctrl_mem_wait_timer.sv | 30 +++
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazState_t;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         STALL_CNT_W = 16;

  // True when the load in EX writes a register that the instruction in ID reads.
  function automatic logic isLoadUse(
    input logic       exMemRead,
    input logic [4:0] exRt,
    input logic [4:0] idRs,
    input logic [4:0] idRt,
    input logic       idUsesRt
  );
    return exMemRead && (exRt != REG_ZERO) &&
           ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_mem_wait_timer.sv
// Counts MEM_WAIT cycles; expired flags the last allowed wait cycle.
module mem_wait_timer #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  // Clear wins over increment so a fresh wait always starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: load-use bubbles, branch flushes and
// memory-wait freezes with a watchdog. Define HAZARD_STALL_CNT_EN to add the
// StallCount port and its saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRt,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_Rt,
  input  logic       BranchTaken,
  input  logic       MemReq,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IFIDFlush,
  output logic       IDEXBubble,
  output logic       PipeFreeze,
  output logic       MemTimeout
`ifdef HAZARD_STALL_CNT_EN
  , output logic [STALL_CNT_W-1:0] StallCount
`endif
);

  hazState_t state;
  hazState_t nextState;
  logic      loadUse;
  logic      memStall;
  logic      freeze;
  logic      timerClear;
  logic      timerInc;
  logic      timerExpired;
  logic      timeoutSet;

  mem_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) uTimer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timerClear),
    .inc    (timerInc),
    .expired(timerExpired)
  );

  // Decide freeze/next state, then derive Mealy outputs by priority.
  always_comb begin
    loadUse    = isLoadUse(EX_MemRead, EX_Rt, ID_Rs, ID_Rt, ID_UsesRt);
    memStall   = MemReq & ~MemReady;
    freeze     = 1'b0;
    nextState  = state;
    timerClear = 1'b0;
    timerInc   = 1'b0;
    timeoutSet = 1'b0;

    case (state)
      RUN: begin
        if (memStall) begin
          freeze     = 1'b1;
          nextState  = MEM_WAIT;
          timerClear = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (MemReady) begin
          nextState = RUN;
        end else if (timerExpired) begin
          nextState  = RUN;
          timeoutSet = 1'b1;
        end else begin
          freeze   = 1'b1;
          timerInc = 1'b1;
        end
      end
      default: nextState = RUN;
    endcase

    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    PipeFreeze = 1'b0;

    if (rst) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end else if (freeze) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      PipeFreeze = 1'b1;
    end else if (loadUse) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end else if (BranchTaken) begin
      IFIDFlush = 1'b1;
    end
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MemTimeout <= 1'b0;
    end else if (timeoutSet) begin
      MemTimeout <= 1'b1;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= '0;
    end else if (!PCWrite && (StallCount != '1)) begin
      StallCount <= StallCount + 1'b1;
    end
  end
`endif

endmodule
